memif_resp: RTL
===============

Name: memif_resp

Overview:
- Memory/IO responder for the execution unit's memory request interface; the other end of the addr/wr_data/we/m_io/byteop/mem_rdy handshake.
- Accepts one request at a time, runs it on a 16-bit Wishbone-style bus, returns read data on memout and pulses mem_rdy when done.
- Splits word accesses at odd addresses into two byte-lane bus cycles, so the core never sees alignment.

Parameters:
- TIMEOUT, 255, bus cycles to wait for wb_ack_i before aborting. Used only with MEMIF_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- req  input  1  request valid (core's mem_op); held until mem_rdy
- addr  input  20  byte address
- wr_data  input  16  write data; byte writes use [7:0]
- we  input  1  1 = write, 0 = read
- m_io  input  1  1 = IO space, 0 = memory
- byteop  input  1  1 = byte access, 0 = word access
- memout  output  16  read data, held until the next read completes
- mem_rdy  output  1  one-cycle completion pulse
- wb_adr_o  output  19  word address (byte address bits [19:1])
- wb_dat_o  output  16  write data
- wb_dat_i  input  16  read data
- wb_sel_o  output  2  byte lane enables; [0] = even byte, [1] = odd byte
- wb_we_o  output  1  write enable
- wb_tga_o  output  1  IO tag (copy of m_io)
- wb_cyc_o  output  1  bus cycle
- wb_stb_o  output  1  strobe
- wb_ack_i  input  1  bus acknowledge; may be asserted in the same cycle as stb

Behaviour:
- Reset (asynchronous, rst=1): state IDLE; memout=16'h0000; mem_rdy, wb_cyc_o, wb_stb_o, wb_we_o, wb_tga_o = 0; wb_sel_o=2'b00; wb_adr_o=0; wb_dat_o=0. Reset during any state aborts immediately with no mem_rdy.
- All outputs are registered.
- split = !byteop && addr[0].

FSM:
- IDLE: when req=1 and mem_rdy=0, latch addr, wr_data, we, m_io, byteop, then go to ACC1. Bus outputs are driven for ACC1 from the next cycle.
- ACC1: cyc=stb=1. On wb_ack_i: if split, go to ACC2 (cyc stays high, stb stays high, address and lane change next cycle); otherwise go to RDY.
- ACC2: cyc=stb=1. On wb_ack_i, go to RDY.
- RDY: mem_rdy=1 for exactly one cycle, cyc=stb=0, then IDLE. The IDLE guard on mem_rdy stops the same request being reissued in the RDY→IDLE cycle.

Lane and address mapping (A = latched addr):
- Byte, A[0]=0: adr=A[19:1], sel=01, dat_o={wr_data[7:0],wr_data[7:0]}. Read: memout={8'h00, wb_dat_i[7:0]}.
- Byte, A[0]=1: adr=A[19:1], sel=10, dat_o as above. Read: memout={8'h00, wb_dat_i[15:8]}.
- Word, even: sel=11, dat_o=wr_data. Read: memout=wb_dat_i.
- Word, odd, ACC1: adr=A[19:1], sel=10, dat_o={wr_data[7:0],wr_data[7:0]}. Read: memout[7:0]=wb_dat_i[15:8].
- Word, odd, ACC2: adr=A[19:1]+1, sel=01, dat_o={wr_data[15:8],wr_data[15:8]}. Read: memout[15:8]=wb_dat_i[7:0].
- The ACC2 address increment is 19-bit modulo: word 0x7FFFF+1 wraps to 0x00000.

Timing and handshake rules:
- Latency with zero-wait ack: non-split request seen in cycle 0 → stb in cycle 1 → mem_rdy in cycle 2. Split: stb in cycles 1–2, mem_rdy in cycle 3. Each ack wait-state adds one cycle.
- memout updates only on read acks; it is unchanged on writes.
- req dropping mid-access does not abort: the bus cycle completes and mem_rdy still pulses.
- Inputs are sampled only in IDLE.

Optional Feature:
- Macro: MEMIF_TIMEOUT_EN.
- Enabled:
  - An 8+ bit counter resets on each strobe phase entry and counts cycles with stb=1 and no ack.
  - When the count reaches TIMEOUT, cyc and stb drop, the remaining phase is skipped, and the FSM goes to RDY.
  - On a timed-out read, memout=16'hFFFF.
  - Extra output port bus_err (1 bit) is set on timeout, is sticky, and clears only on rst.
- Disabled: no counter and no bus_err port; the block waits for ack indefinitely.

Test Plan:
- Read word, addr=20'h00100, zero-wait ack, wb_dat_i=16'hBEEF → wb_adr_o=19'h00080, sel=11, mem_rdy in cycle 2, memout=16'hBEEF.
- Write byte, addr=20'h00101, wr_data=16'h12A5, m_io=1 → sel=10, dat_o=16'hA5A5, we=1, tga=1, single stb, mem_rdy in cycle 2.
- Read word, addr=20'h00203 (split), ACC1 data 16'h34xx, ACC2 data 16'hxx12 → adr 19'h00101 then 19'h00102, sel 10 then 01, memout=16'h1234, mem_rdy in cycle 3.
- Write word at 20'hFFFFF → second phase adr=19'h00000, sel=01, dat_o=16'hHHHH where HH = wr_data[15:8]; ack delayed 2 cycles per phase → mem_rdy in cycle 7.
- rst asserted during ACC2 of a split read → cyc/stb/mem_rdy go to 0 immediately; the next request starts cleanly from ACC1.
- With MEMIF_TIMEOUT_EN and TIMEOUT=4, read with no ack → stb drops after 4 cycles, mem_rdy pulses, memout=16'hFFFF, bus_err=1 and stays 1.

Source files
------------

// File: rtl/memif_resp_if.sv
// memif_resp_if: core request handshake plus 16-bit Wishbone master bus for memif_resp.
// slave = the responder's view, master = the requester/bus-model view.
interface memif_resp_if;
  logic        req;
  logic [19:0] addr;
  logic [15:0] wr_data;
  logic        we;
  logic        m_io;
  logic        byteop;
  logic [15:0] memout;
  logic        mem_rdy;

  logic [18:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic [1:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_tga_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;

  modport slave (
    input  req, addr, wr_data, we, m_io, byteop, wb_dat_i, wb_ack_i,
    output memout, mem_rdy, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_tga_o, wb_cyc_o, wb_stb_o
  );

  modport master (
    output req, addr, wr_data, we, m_io, byteop, wb_dat_i, wb_ack_i,
    input  memout, mem_rdy, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_tga_o, wb_cyc_o, wb_stb_o
  );
endinterface

// File: rtl/memif_resp.sv
// memif_resp: single-outstanding memory/IO responder; odd-address words become two byte-lane bus cycles.
// Define MEMIF_TIMEOUT_EN to add an ack timeout (parameter TIMEOUT) with a sticky bus_err output.
module memif_resp
`ifdef MEMIF_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT = 255)
`endif
(
  input logic         clk,
  input logic         rst,
  memif_resp_if.slave bus
`ifdef MEMIF_TIMEOUT_EN
  ,
  output logic        bus_err
`endif
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RDY} state_t;

  state_t      state;
  logic [19:0] lat_addr;
  logic [7:0]  lat_hi;
  logic        lat_we;
  logic        lat_byteop;
  logic        lat_split;
  logic        accept;
  logic        tmo_hit;
  logic        finish;

  function automatic logic [1:0] lane_sel(input logic bop, input logic a0);
    return a0 ? 2'b10 : (bop ? 2'b01 : 2'b11);
  endfunction

  function automatic logic [15:0] lane_dat(input logic bop, input logic a0, input logic [15:0] wd);
    return (bop || a0) ? {wd[7:0], wd[7:0]} : wd;
  endfunction

  // First-phase read merge; an odd word keeps the high byte for the second phase.
  function automatic logic [15:0] first_rd(input logic bop, input logic a0,
                                           input logic [15:0] d, input logic [15:0] cur);
    if (bop) return {8'h00, (a0 ? d[15:8] : d[7:0])};
    if (a0)  return {cur[15:8], d[15:8]};
    return d;
  endfunction

  assign accept    = (state == IDLE) && bus.req && !bus.mem_rdy;
  assign lat_split = !lat_byteop && lat_addr[0];
  assign finish    = ((state == ACC1) && ((bus.wb_ack_i && !lat_split) || tmo_hit)) ||
                     ((state == ACC2) && (bus.wb_ack_i || tmo_hit));

  // Request capture: data-only registers, loaded once per accepted request.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_addr   <= bus.addr;
      lat_hi     <= bus.wr_data[15:8];
      lat_we     <= bus.we;
      lat_byteop <= bus.byteop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bus.memout   <= 16'h0000;
      bus.mem_rdy  <= 1'b0;
      bus.wb_cyc_o <= 1'b0;
      bus.wb_stb_o <= 1'b0;
      bus.wb_we_o  <= 1'b0;
      bus.wb_tga_o <= 1'b0;
      bus.wb_sel_o <= 2'b00;
      bus.wb_adr_o <= 19'h00000;
      bus.wb_dat_o <= 16'h0000;
    end else begin
      bus.mem_rdy <= finish;
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= ACC1;
            bus.wb_cyc_o <= 1'b1;
            bus.wb_stb_o <= 1'b1;
            bus.wb_we_o  <= bus.we;
            bus.wb_tga_o <= bus.m_io;
            bus.wb_adr_o <= bus.addr[19:1];
            bus.wb_sel_o <= lane_sel(bus.byteop, bus.addr[0]);
            bus.wb_dat_o <= lane_dat(bus.byteop, bus.addr[0], bus.wr_data);
          end
        end
        ACC1: begin
          if (bus.wb_ack_i) begin
            if (!lat_we) bus.memout <= first_rd(lat_byteop, lat_addr[0], bus.wb_dat_i, bus.memout);
            if (lat_split) begin
              // Second half of an odd word: next word, even lane, wraps at the top of memory.
              state        <= ACC2;
              bus.wb_adr_o <= lat_addr[19:1] + 19'd1;
              bus.wb_sel_o <= 2'b01;
              bus.wb_dat_o <= {lat_hi, lat_hi};
            end
          end else if (tmo_hit && !lat_we) begin
            bus.memout <= 16'hFFFF;
          end
        end
        ACC2: begin
          if (bus.wb_ack_i && !lat_we) begin
            bus.memout <= {bus.wb_dat_i[7:0], bus.memout[7:0]};
          end else if (tmo_hit && !lat_we) begin
            bus.memout <= 16'hFFFF;
          end
        end
        RDY:     state <= IDLE;
        default: state <= IDLE;
      endcase
      if (finish) begin
        state        <= RDY;
        bus.wb_cyc_o <= 1'b0;
        bus.wb_stb_o <= 1'b0;
        bus.wb_we_o  <= 1'b0;
        bus.wb_sel_o <= 2'b00;
      end
    end
  end

`ifdef MEMIF_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] tmo_cnt;

  assign tmo_hit = bus.wb_stb_o && !bus.wb_ack_i && (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // Counter restarts whenever a new strobe phase begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      bus_err <= 1'b0;
    end else begin
      if (accept || ((state == ACC1) && bus.wb_ack_i)) begin
        tmo_cnt <= '0;
      end else if (bus.wb_stb_o && !bus.wb_ack_i) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (tmo_hit) bus_err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

endmodule
